// File: rtl/ones_pattern_gen.sv
// Emits every WIDTH-bit word with exactly N set bits, in ascending order,
// one per valid/ready handshake (the inverse of a popcount).
module ones_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int CW    = 4,
  parameter int IW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CW-1:0]    count_in,
  output logic             busy,
  output logic             data_valid,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             last,
  output logic [IW-1:0]    pat_idx,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // N ones packed into the LSBs: the first pattern of a stream.
  function automatic logic [WIDTH-1:0] low_mask(input logic [CW-1:0] n);
    logic [WIDTH-1:0] m;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

  // N ones packed into the MSBs: the final pattern of a stream.
  function automatic logic [WIDTH-1:0] top_mask(input logic [CW-1:0] n);
    logic [WIDTH-1:0] m;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = (i >= WIDTH - int'(n));
    end
    return m;
  endfunction

  // Gosper successor in WIDTH+1 bits; the divide by the lowest set bit
  // becomes a right shift by its index.
  function automatic logic [WIDTH:0] gosper_next(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] xe;
    logic [WIDTH:0] c;
    logic [WIDTH:0] r;
    logic [WIDTH:0] t;
    int             tz;
    xe = {1'b0, x};
    c  = xe & (~xe + {{WIDTH{1'b0}}, 1'b1});
    r  = xe + c;
    tz = 0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (x[i]) begin
        tz = i;
      end
    end
    t = ((r ^ xe) >> 2) >> tz;
    return t | r;
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    n_q, n_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             last_q, last_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH:0]   succ_s;

  assign succ_s = gosper_next(data_q);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count_in > CW'(WIDTH)) begin
            err_d = 1'b1;
          end else begin
            n_d     = count_in;
            data_d  = low_mask(count_in);
            idx_d   = {IW{1'b0}};
            last_d  = (count_in == {CW{1'b0}}) || (count_in == CW'(WIDTH));
            valid_d = 1'b1;
            busy_d  = 1'b1;
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (valid_q && data_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            // The successor is only taken below the top pattern, so it never wraps.
            data_d = succ_s[WIDTH-1:0];
            idx_d  = idx_q + IW'(1);
            last_d = (succ_s == {1'b0, top_mask(n_q)});
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= {CW{1'b0}};
      data_q  <= {WIDTH{1'b0}};
      idx_q   <= {IW{1'b0}};
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign busy       = busy_q;
  assign data_valid = valid_q;
  assign data_out   = data_q;
  assign last       = last_q;
  assign pat_idx    = idx_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Randomized bench for ones_pattern_gen: a transaction-level model built from
// an enumeration of all 8-bit words is compared against the DUT every cycle.
module tb_ones_pattern_gen;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] count_in;
  logic       busy;
  logic       data_valid;
  logic       data_ready;
  logic [7:0] data_out;
  logic       last;
  logic [7:0] pat_idx;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;
  int totals[9] = '{1, 8, 28, 56, 70, 56, 28, 8, 1};

  // Model state
  bit m_busy = 0;
  bit m_emit = 0;
  bit m_done = 0;
  bit m_err  = 0;
  int m_n    = 0;
  int m_beat = 0;
  int hs_cnt = 0;

  ones_pattern_gen #(.WIDTH(8), .CW(4), .IW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .count_in(count_in),
    .busy(busy), .data_valid(data_valid), .data_ready(data_ready),
    .data_out(data_out), .last(last), .pat_idx(pat_idx),
    .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic int count_patterns(input int n);
    int c = 0;
    for (int v = 0; v < 256; v++) if ($countones(v) == n) c++;
    return c;
  endfunction

  // k-th (zero-based) 8-bit value, ascending, with exactly n ones
  function automatic int pattern_at(input int n, input int k);
    int c = 0;
    for (int v = 0; v < 256; v++) begin
      if ($countones(v) == n) begin
        if (c == k) return v;
        c++;
      end
    end
    return -1;
  endfunction

  // Reference model: advances on each clock edge from the sampled inputs.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 0; m_emit = 0; m_done = 0; m_err = 0; m_beat = 0;
      end else begin
        m_done = 0;
        m_err  = 0;
        if (!m_busy) begin
          if (start) begin
            if (count_in > 4'd8) m_err = 1;
            else begin
              m_n = int'(count_in); m_beat = 0; m_busy = 1; m_emit = 1;
            end
          end
        end else if (m_emit) begin
          if (data_ready) begin
            hs_cnt++;
            if (m_beat == count_patterns(m_n) - 1) begin
              m_emit = 0; m_done = 1;
            end else m_beat++;
          end
        end else begin
          m_busy = 0;
        end
      end
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", int'(busy), int'(m_busy));
      chk("data_valid", int'(data_valid), int'(m_emit));
      chk("done", int'(done), int'(m_done));
      chk("err", int'(err), int'(m_err));
      if (m_emit) begin
        chk("data_out", int'(data_out), pattern_at(m_n, m_beat));
        chk("pat_idx", int'(pat_idx), m_beat);
        chk("last", int'(last), int'(m_beat == count_patterns(m_n) - 1));
        chk("popcount", $countones(data_out), m_n);
      end else begin
        chk("last_idle", int'(last), 0);
      end
    end
  end

  task automatic wait_done(input int pct);
    bit got = 0;
    for (int c = 0; c < 3000; c++) begin
      if (done === 1'b1) begin
        got = 1;
        break;
      end
      data_ready = ($urandom_range(0, 99) < pct);
      start      = ($urandom_range(0, 7) == 0);
      count_in   = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    start = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: done not seen, expected within 3000 cycles");
    end
  endtask

  task automatic run_n(input int n, input int pct);
    @(negedge clk);
    hs_cnt   = 0;
    start    = 1'b1;
    count_in = 4'(n);
    @(negedge clk);
    start = 1'b0;
    if (n > 8) begin
      chk("err_pulse", int'(err), 1);
      chk("err_busy", int'(busy), 0);
      chk("err_valid", int'(data_valid), 0);
    end else begin
      wait_done(pct);
      chk($sformatf("beats_N%0d", n), hs_cnt, totals[n]);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; count_in = 4'd0; data_ready = 1'b0;

    // Pin the model against hand-computed values
    chk("pin_n2_0", pattern_at(2, 0), 8'h03);
    chk("pin_n2_1", pattern_at(2, 1), 8'h05);
    chk("pin_n2_2", pattern_at(2, 2), 8'h06);
    chk("pin_n2_3", pattern_at(2, 3), 8'h09);
    chk("pin_n2_27", pattern_at(2, 27), 8'hC0);
    chk("pin_n3_0", pattern_at(3, 0), 8'h07);
    chk("pin_cnt4", count_patterns(4), 70);
    chk("pin_cnt2", count_patterns(2), 28);

    repeat (2) @(negedge clk);
    chk("rst_valid", int'(data_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_data", int'(data_out), 0);
    chk("rst_idx", int'(pat_idx), 0);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a stream
    @(negedge clk);
    start = 1'b1; count_in = 4'd4; data_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(data_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_data", int'(data_out), 0);
    chk("arst_idx", int'(pat_idx), 0);
    chk("arst_last", int'(last), 0);
    chk("arst_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1; count_in = 4'd3; hs_cnt = 0;
    @(negedge clk);
    start = 1'b0;
    chk("post_rst_first", int'(data_out), 8'h07);
    chk("post_rst_valid", int'(data_valid), 1);
    wait_done(100);
    chk("beats_post_rst", hs_cnt, 56);

    run_n(2, 100);
    run_n(0, 100);
    run_n(8, 100);
    run_n(4, 50);
    run_n(9, 100);
    run_n(15, 100);
    run_n(1, 60);
    for (int n = 0; n <= 8; n++) run_n(n, 75);
    repeat (12) run_n($urandom_range(0, 10), $urandom_range(20, 100));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
